// File: rtl/a2audio_pkg.sv
// Shared speaker/mixer types and constants for the audio path.
// SPEAKER_RAMP_EN adds the RAMP state (linear fade after the hold window).
package a2audio_pkg;

`ifdef SPEAKER_RAMP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RAMP = 2'd2} spk_state_e;
`else
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} spk_state_e;
`endif

  localparam logic [13:0] SPEAKER_AMPLITUDE  = 14'd8192;
  localparam logic [7:0]  SPEAKER_HOLD_TICKS = 8'd255;
  localparam logic [13:0] SPEAKER_RAMP_STEP  = 14'd512;
  localparam logic [15:0] MIX_SAT_MAX        = 16'h7FFF;

  function automatic logic [13:0] ramp_next(input logic [13:0] lvl);
    return (lvl > SPEAKER_RAMP_STEP) ? (lvl - SPEAKER_RAMP_STEP) : '0;
  endfunction

  function automatic logic [15:0] mix_sat(input logic [16:0] sum);
    return (sum > {1'b0, MIX_SAT_MAX}) ? MIX_SAT_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/speaker_pulse.sv
// Speaker toggle synchroniser, edge flag and hold/ramp FSM producing the amplitude.
// SPEAKER_RAMP_EN enables the RAMP fade; otherwise HOLD exits straight to IDLE.
module speaker_pulse
  import a2audio_pkg::*;
(
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        sample_strobe_i,
  input  logic        speaker_bit_i,
  input  logic        speaker_en_i,
  output logic [13:0] amplitude_o
);

  logic        sync_1, sync_2, sync_2_d;
  logic [1:0]  prime_cnt;
  logic        edge_pending;
  spk_state_e  state_q;
  logic [7:0]  hold_cnt;
  logic        edge_det, edge_seen;
  logic [13:0] bit_level;
`ifdef SPEAKER_RAMP_EN
  logic [13:0] ramp_level;
  logic [13:0] ramp_nx;
`endif

  // Edges are ignored until the chain holds only post-reset samples.
  assign edge_det  = (prime_cnt == 2'd3) && (sync_2 != sync_2_d);
  assign edge_seen = edge_pending | edge_det;
  assign bit_level = sync_2 ? SPEAKER_AMPLITUDE : '0;
`ifdef SPEAKER_RAMP_EN
  assign ramp_nx   = ramp_next((state_q == HOLD) ? bit_level : ramp_level);
`endif

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sync_1       <= 1'b0;
      sync_2       <= 1'b0;
      sync_2_d     <= 1'b0;
      prime_cnt    <= '0;
      edge_pending <= 1'b0;
      state_q      <= IDLE;
      hold_cnt     <= '0;
      amplitude_o  <= '0;
`ifdef SPEAKER_RAMP_EN
      ramp_level   <= '0;
`endif
    end else begin
      sync_1   <= speaker_bit_i;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
      if (prime_cnt != 2'd3) prime_cnt <= prime_cnt + 2'd1;

      if (sample_strobe_i) begin
        edge_pending <= 1'b0;
        if (edge_seen) begin
          state_q     <= HOLD;
          hold_cnt    <= SPEAKER_HOLD_TICKS;
          amplitude_o <= speaker_en_i ? bit_level : '0;
        end else begin
          case (state_q)
            HOLD: begin
              if (hold_cnt > 8'd1) begin
                hold_cnt    <= hold_cnt - 8'd1;
                amplitude_o <= speaker_en_i ? bit_level : '0;
              end else begin
                hold_cnt <= '0;
`ifdef SPEAKER_RAMP_EN
                // The exit strobe already applies the first ramp step.
                ramp_level  <= ramp_nx;
                state_q     <= (ramp_nx == '0) ? IDLE : RAMP;
                amplitude_o <= speaker_en_i ? ramp_nx : '0;
`else
                state_q     <= IDLE;
                amplitude_o <= '0;
`endif
              end
            end
`ifdef SPEAKER_RAMP_EN
            RAMP: begin
              ramp_level  <= ramp_nx;
              state_q     <= (ramp_nx == '0) ? IDLE : RAMP;
              amplitude_o <= speaker_en_i ? ramp_nx : '0;
            end
`endif
            default: amplitude_o <= '0;
          endcase
        end
      end else if (edge_det) begin
        edge_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_mix.sv
// Two-stage mixer: Mockingboard samples plus speaker amplitude, saturated to 15 bits.
// SPEAKER_RAMP_EN is forwarded to speaker_pulse (RAMP fade after hold).
module audio_mix
  import a2audio_pkg::*;
(
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        sample_strobe_i,
  input  logic        speaker_bit_i,
  input  logic        speaker_en_i,
  input  logic [9:0]  mb_audio_l_i,
  input  logic [9:0]  mb_audio_r_i,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        sample_valid_o
);

  logic [13:0] spk_amp;
  logic        stage1_valid;
  logic [9:0]  mb_l_q, mb_r_q;
  logic [16:0] sum_l, sum_r;

  // spk_amp is registered on the strobe inside speaker_pulse: it is the stage-1 amplitude.
  speaker_pulse u_spk (
    .clk_pixel       (clk_pixel),
    .reset           (reset),
    .sample_strobe_i (sample_strobe_i),
    .speaker_bit_i   (speaker_bit_i),
    .speaker_en_i    (speaker_en_i),
    .amplitude_o     (spk_amp)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      stage1_valid <= 1'b0;
      mb_l_q       <= '0;
      mb_r_q       <= '0;
    end else begin
      stage1_valid <= sample_strobe_i;
      if (sample_strobe_i) begin
        mb_l_q <= mb_audio_l_i;
        mb_r_q <= mb_audio_r_i;
      end
    end
  end

  assign sum_l = {3'b000, mb_l_q, 4'b0000} + {3'b000, spk_amp};
  assign sum_r = {3'b000, mb_r_q, 4'b0000} + {3'b000, spk_amp};

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      audio_l_o      <= '0;
      audio_r_o      <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      sample_valid_o <= stage1_valid;
      if (stage1_valid) begin
        audio_l_o <= mix_sat(sum_l);
        audio_r_o <= mix_sat(sum_r);
      end
    end
  end

endmodule

// File: tb/tb_audio_mix.sv
// Self-checking bench for audio_mix: directed vectors plus random strobes against a
// strobe-count reference model of the speaker envelope.
module tb_audio_mix;
  import a2audio_pkg::*;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic        sample_strobe_i = 1'b0;
  logic        speaker_bit_i = 1'b0;
  logic        speaker_en_i = 1'b0;
  logic [9:0]  mb_audio_l_i = '0;
  logic [9:0]  mb_audio_r_i = '0;
  logic [15:0] audio_l_o, audio_r_o;
  logic        sample_valid_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  bit          sb_off = 1'b0;

  always #5 clk_pixel = ~clk_pixel;

  audio_mix dut (
    .clk_pixel       (clk_pixel),
    .reset           (reset),
    .sample_strobe_i (sample_strobe_i),
    .speaker_bit_i   (speaker_bit_i),
    .speaker_en_i    (speaker_en_i),
    .mb_audio_l_i    (mb_audio_l_i),
    .mb_audio_r_i    (mb_audio_r_i),
    .audio_l_o       (audio_l_o),
    .audio_r_o       (audio_r_o),
    .sample_valid_o  (sample_valid_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int spk_amp(input bit have, input bit lvl, input int unsigned n);
    int a;
    if (!have || !lvl) return 0;
    if (n <= 254) return 8192;
`ifdef SPEAKER_RAMP_EN
    a = 8192 - 512 * (int'(n) - 254);
    return (a < 0) ? 0 : a;
`else
    a = 0;
    return a;
`endif
  endfunction

  function automatic logic [15:0] ref_mix(input logic [9:0] mb, input int amp);
    int s;
    s = int'(mb) * 16 + amp;
    return (s > 32767) ? 16'h7FFF : 16'(s);
  endfunction

  typedef struct {
    int unsigned due;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned edge_cnt = 0;
  bit          m0 = 0, m1 = 0, m2 = 0;
  int unsigned n_samp = 0;
  bit          pend = 0, have_edge = 0, lvl = 0;
  int unsigned since = 0;
  bit          exp_valid = 0;
  logic [15:0] exp_l = '0, exp_r = '0;

  // m1/m2: speaker bit as sampled two/three clocks ago (the synchronised view).
  always @(posedge clk_pixel) begin
    exp_t e;
    int   a;
    edge_cnt++;
    if (reset) begin
      exp_q.delete();
      m0 = 0; m1 = 0; m2 = 0; n_samp = 0;
      pend = 0; have_edge = 0; since = 0;
      exp_valid = 0; exp_l = '0; exp_r = '0;
    end else begin
      exp_valid = 0;
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
        e = exp_q.pop_front();
        exp_valid = 1; exp_l = e.l; exp_r = e.r;
      end
      if (n_samp >= 3 && m1 != m2) pend = 1;
      if (sample_strobe_i) begin
        if (pend) begin have_edge = 1; since = 0; lvl = m1; end
        else if (since < 100000) since++;
        pend = 0;
        a = speaker_en_i ? spk_amp(have_edge, lvl, since) : 0;
        e.due = edge_cnt + 1;
        e.l = ref_mix(mb_audio_l_i, a);
        e.r = ref_mix(mb_audio_r_i, a);
        exp_q.push_back(e);
      end
      m2 = m1; m1 = m0; m0 = speaker_bit_i;
      if (n_samp < 3) n_samp++;
    end
  end

  always @(negedge clk_pixel) begin
    if (!sb_off && edge_cnt > 0) begin
      check("sb_valid", 32'(sample_valid_o), 32'(exp_valid));
      check("sb_left", 32'(audio_l_o), 32'(exp_l));
      check("sb_right", 32'(audio_r_o), 32'(exp_r));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge clk_pixel); #1; end
  endtask

  task automatic strobe(input logic [9:0] l, input logic [9:0] r);
    mb_audio_l_i = l; mb_audio_r_i = r; sample_strobe_i = 1'b1;
    tick(1);
    sample_strobe_i = 1'b0;
  endtask

  typedef struct {
    logic [9:0]  l;
    logic [9:0]  r;
    logic        en;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{10'h3FF, 10'h000, 1'b0, 16'd16368, 16'd0};
    vecs[1] = '{10'h000, 10'h3FF, 1'b1, 16'd0,     16'd16368};
    vecs[2] = '{10'h001, 10'h002, 1'b1, 16'd16,    16'd32};
    vecs[3] = '{10'h155, 10'h2AA, 1'b0, 16'd5456,  16'd10912};
    vecs[4] = '{10'h200, 10'h1FF, 1'b1, 16'd8192,  16'd8176};

    tick(3);
    check("rst_left", 32'(audio_l_o), 32'd0);
    check("rst_right", 32'(audio_r_o), 32'd0);
    check("rst_valid", 32'(sample_valid_o), 32'd0);
    check("rst_hold_cnt", 32'(dut.u_spk.hold_cnt), 32'd0);
    check("rst_state", 32'(dut.u_spk.state_q), 32'(IDLE));
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 5; i++) begin
      speaker_en_i = vecs[i].en;
      strobe(vecs[i].l, vecs[i].r);
      check("vec_early_valid", 32'(sample_valid_o), 32'd0);
      tick(1);
      check("vec_valid", 32'(sample_valid_o), 32'd1);
      check("vec_left", 32'(audio_l_o), 32'(vecs[i].exp_l));
      check("vec_right", 32'(audio_r_o), 32'(vecs[i].exp_r));
      tick(1);
      check("vec_single_pulse", 32'(sample_valid_o), 32'd0);
      check("vec_hold_left", 32'(audio_l_o), 32'(vecs[i].exp_l));
    end

    // speaker edge, hold window, then exit
    speaker_bit_i = 1'b1;
    tick(4);
    speaker_en_i = 1'b1;
    strobe(10'h0, 10'h0);
    tick(1);
    check("spk_hold_left", 32'(audio_l_o), 32'd8192);
    check("spk_hold_right", 32'(audio_r_o), 32'd8192);
    for (int i = 1; i < 255; i++) begin
      strobe(10'h0, 10'h0);
      tick(1);
    end
    strobe(10'h0, 10'h0);
    tick(1);
`ifdef SPEAKER_RAMP_EN
    check("spk_after_hold", 32'(audio_l_o), 32'd7680);
`else
    check("spk_after_hold", 32'(audio_l_o), 32'd0);
`endif
    tick(2);

    // reload from HOLD with hold_cnt=3 by an edge coincident with the strobe
    speaker_bit_i = 1'b0;
    tick(4);
    strobe(10'h0, 10'h0);
    for (int i = 0; i < 252; i++) begin
      strobe(10'h0, 10'h0);
      tick(1);
    end
    check("pre_reload_cnt", 32'(dut.u_spk.hold_cnt), 32'd3);
    check("pre_reload_state", 32'(dut.u_spk.state_q), 32'(HOLD));
    speaker_bit_i = 1'b1;
    tick(2);
    strobe(10'h0, 10'h0);
    check("reload_cnt", 32'(dut.u_spk.hold_cnt), 32'd255);
    tick(1);
    check("reload_amp", 32'(audio_l_o), 32'd8192);
    strobe(10'h0, 10'h0);
    check("reload_no_repeat", 32'(dut.u_spk.hold_cnt), 32'd254);
    tick(1);

    // mix sum and saturation
    strobe(10'h3FF, 10'h3FF);
    tick(1);
    check("mix_max_left", 32'(audio_l_o), 32'd24560);
    check("mix_max_right", 32'(audio_r_o), 32'd24560);
    sb_off = 1'b1;
    force dut.sum_l = 17'h10000;
    force dut.sum_r = 17'h10000;
    strobe(10'h0, 10'h0);
    tick(1);
    check("sat_valid", 32'(sample_valid_o), 32'd1);
    check("sat_left", 32'(audio_l_o), 32'h7FFF);
    check("sat_right", 32'(audio_r_o), 32'h7FFF);
    release dut.sum_l;
    release dut.sum_r;

    // back-to-back strobes
    speaker_en_i = 1'b0;
    mb_audio_l_i = 10'h123; mb_audio_r_i = 10'h3C0; sample_strobe_i = 1'b1;
    tick(1);
    mb_audio_l_i = 10'h0F0; mb_audio_r_i = 10'h00F;
    tick(1);
    sample_strobe_i = 1'b0;
    check("b2b_valid_a", 32'(sample_valid_o), 32'd1);
    check("b2b_left_a", 32'(audio_l_o), 32'd4656);
    check("b2b_right_a", 32'(audio_r_o), 32'd15360);
    tick(1);
    check("b2b_valid_b", 32'(sample_valid_o), 32'd1);
    check("b2b_left_b", 32'(audio_l_o), 32'd3840);
    check("b2b_right_b", 32'(audio_r_o), 32'd240);
    tick(1);
    check("b2b_end", 32'(sample_valid_o), 32'd0);
    sb_off = 1'b0;

    // reset one cycle after a strobe
    speaker_en_i = 1'b1;
    strobe(10'h100, 10'h100);
    reset = 1'b1;
    tick(1);
    check("midrst_valid", 32'(sample_valid_o), 32'd0);
    check("midrst_left", 32'(audio_l_o), 32'd0);
    check("midrst_right", 32'(audio_r_o), 32'd0);
    check("midrst_state", 32'(dut.u_spk.state_q), 32'(IDLE));
    check("midrst_cnt", 32'(dut.u_spk.hold_cnt), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("midrst_no_pulse", 32'(sample_valid_o), 32'd0);
    tick(3);

    // random traffic checked by the model
    for (int i = 0; i < 1500; i++) begin
      int unsigned gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < int'(gap); g++) begin
        if ((i % 600) < 100 && $urandom_range(0, 19) == 0) speaker_bit_i = ~speaker_bit_i;
        tick(1);
      end
      if (i == 700) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      speaker_en_i = ($urandom_range(0, 7) != 0);
      strobe(10'($urandom), 10'($urandom));
    end
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
